pipe_ctrl: RTL and testbench

- Central pipeline controller and producer of the 6-bit stall_en bus consumed by every inter-stage pipeline register (pc, if/id, id/ex, ex/mem, mem/wb).
- Arbitrates stall requests from ID, EX and MEM, sequences exception/ERET flushes and supplies the redirect PC.
- Keeps a stall-cycle performance counter and a stuck-stall watchdog.

---
 rtl/pipe_ctrl_if.sv | 28 ++
 rtl/pipe_ctrl.sv | 106 ++++++++++
 tb/tb_pipe_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle between pipe_ctrl (master) and the pipeline stages (slave).
// Carries the stall requests and exception inputs, plus the stall/flush/redirect outputs.
interface pipe_ctrl_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        excp_valid;
  logic        excp_eret;
  logic [31:0] cp0_epc;
  logic        perf_clr;
  logic [5:0]  stall_en;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles;
  logic        stall_timeout;

  modport master (
    input  stallreq_id, stallreq_ex, stallreq_mem,
    input  excp_valid, excp_eret, cp0_epc, perf_clr,
    output stall_en, flush, new_pc, stall_cycles, stall_timeout
  );

  modport slave (
    output stallreq_id, stallreq_ex, stallreq_mem,
    output excp_valid, excp_eret, cp0_epc, perf_clr,
    input  stall_en, flush, new_pc, stall_cycles, stall_timeout
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall arbitration, exception/ERET flush sequencing,
// stall-cycle performance counter and stuck-stall watchdog.
//
//   state | meaning
//   RUN   | normal operation, a committed exception flushes and redirects
//   HOLD  | post-flush window, exceptions ignored, stalls still arbitrated
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int unsigned FLUSH_HOLD = 1,
  parameter int unsigned MAX_STALL  = 1024
) (
  input  logic clk,
  input  logic reset,
  pipe_ctrl_if.master bus
);

  localparam logic [0:0]  ST_RUN    = 1'b0;
  localparam logic [0:0]  ST_HOLD   = 1'b1;
  localparam logic [3:0]  HOLD_INIT = 4'(FLUSH_HOLD);
  localparam logic [15:0] WD_LIMIT  = 16'(MAX_STALL);

  logic [0:0]  state_q;
  logic [3:0]  hold_cnt_q;
  logic [31:0] stall_cycles_q;
  logic [15:0] consec_q;
  logic        timeout_q;

  logic [5:0]  stall_req;
  logic        excp_take;
  logic        flush_c;
  logic [5:0]  stall_en_c;
  logic [31:0] new_pc_c;
  logic        stalling;

  // Thermometer encoding keeps every hold mask of the form 0..01..1.
  always_comb begin
    stall_req = 6'b000000;
    if (bus.stallreq_mem)     stall_req = 6'b011111;
    else if (bus.stallreq_ex) stall_req = 6'b001111;
    else if (bus.stallreq_id) stall_req = 6'b000111;
  end

  always_comb begin
    excp_take  = (state_q == ST_RUN) && bus.excp_valid;
    flush_c    = excp_take && !reset;
    stall_en_c = (reset || excp_take) ? 6'b000000 : stall_req;
    new_pc_c   = 32'h0;
    if (flush_c) new_pc_c = bus.excp_eret ? bus.cp0_epc : EXC_VECTOR;
  end

  assign stalling = stall_en_c[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      hold_cnt_q <= 4'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (excp_take && (HOLD_INIT != 4'd0)) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= HOLD_INIT;
          end
        end
        default: begin
          if (hold_cnt_q == 4'd1) begin
            state_q    <= ST_RUN;
            hold_cnt_q <= 4'd0;
          end else begin
            hold_cnt_q <= hold_cnt_q - 4'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= 32'h0;
    end else if (bus.perf_clr) begin
      stall_cycles_q <= 32'h0;
    end else if (stalling && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  // A flush forces stall_en to zero, so the non-stalling branch also covers it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      consec_q  <= 16'd0;
      timeout_q <= 1'b0;
    end else if (!stalling) begin
      consec_q <= 16'd0;
    end else if (consec_q != WD_LIMIT) begin
      consec_q <= consec_q + 16'd1;
      if (consec_q == (WD_LIMIT - 16'd1)) timeout_q <= 1'b1;
    end
  end

  assign bus.stall_en      = stall_en_c;
  assign bus.flush         = flush_c;
  assign bus.new_pc        = new_pc_c;
  assign bus.stall_cycles  = stall_cycles_q;
  assign bus.stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with MAX_STALL=4 and FLUSH_HOLD=1.
// Inputs change on the falling edge; outputs are sampled between edges.
module tb_pipe_ctrl;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .EXC_VECTOR(32'h0000_0020),
    .FLUSH_HOLD(1),
    .MAX_STALL (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.stallreq_id  = 1'b0;
    bus.stallreq_ex  = 1'b0;
    bus.stallreq_mem = 1'b0;
    bus.excp_valid   = 1'b0;
    bus.excp_eret    = 1'b0;
    bus.cp0_epc      = 32'h0;
    bus.perf_clr     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    idle_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;

    // Idle after reset
    cyc();
    #1;
    chk("rst_stall_en", 32'(bus.stall_en), 32'h00);
    chk("rst_flush", 32'(bus.flush), 32'h0);
    chk("rst_new_pc", bus.new_pc, 32'h0);
    chk("rst_stall_cycles", bus.stall_cycles, 32'h0);
    chk("rst_timeout", 32'(bus.stall_timeout), 32'h0);

    // ID stall x3 then MEM overrides ID
    cyc();
    bus.stallreq_id = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("id_stall_en", 32'(bus.stall_en), 32'h07);
      cyc();
    end
    bus.stallreq_mem = 1'b1;
    #1 chk("mem_over_id", 32'(bus.stall_en), 32'h1F);
    cyc();
    idle_inputs();
    #1;
    chk("idmem_cycles", bus.stall_cycles, 32'd4);
    chk("idmem_idle_en", 32'(bus.stall_en), 32'h00);
    chk("idmem_timeout", 32'(bus.stall_timeout), 32'h1);
    reset = 1'b1;
    #1;
    chk("async_rst_timeout", 32'(bus.stall_timeout), 32'h0);
    chk("async_rst_cycles", bus.stall_cycles, 32'h0);
    cyc();
    reset = 1'b0;

    // Exception with EX stall, ignored in HOLD, ERET honoured after
    cyc();
    bus.excp_valid  = 1'b1;
    bus.stallreq_ex = 1'b1;
    #1;
    chk("exc_flush", 32'(bus.flush), 32'h1);
    chk("exc_stall_en", 32'(bus.stall_en), 32'h00);
    chk("exc_new_pc", bus.new_pc, 32'h20);
    cyc();
    bus.excp_eret = 1'b1;
    bus.cp0_epc   = 32'h0000_1234;
    #1;
    chk("hold_flush", 32'(bus.flush), 32'h0);
    chk("hold_new_pc", bus.new_pc, 32'h0);
    chk("hold_stall_en", 32'(bus.stall_en), 32'h0F);
    chk("hold_cycles", bus.stall_cycles, 32'd0);
    cyc();
    #1;
    chk("eret_flush", 32'(bus.flush), 32'h1);
    chk("eret_new_pc", bus.new_pc, 32'h1234);
    chk("eret_stall_en", 32'(bus.stall_en), 32'h00);
    cyc();
    idle_inputs();
    #1 chk("exc_seq_cycles", bus.stall_cycles, 32'd1);
    cyc();
    do_reset();

    // Watchdog: 3 stalls, gap, 4 stalls
    bus.stallreq_ex = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      #1 chk("wd_burst1", 32'(bus.stall_timeout), 32'h0);
    end
    bus.stallreq_ex = 1'b0;
    cyc();
    #1 chk("wd_gap", 32'(bus.stall_timeout), 32'h0);
    bus.stallreq_ex = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      #1 chk($sformatf("wd_burst2_%0d", i), 32'(bus.stall_timeout), (i == 4) ? 32'h1 : 32'h0);
    end
    bus.stallreq_ex = 1'b0;
    cyc();
    #1;
    chk("wd_sticky", 32'(bus.stall_timeout), 32'h1);
    chk("wd_cycles", bus.stall_cycles, 32'd7);
    do_reset();

    // Saturation and perf_clr priority
    force dut.stall_cycles_q = 32'hFFFF_FFFD;
    #1 release dut.stall_cycles_q;
    #1 chk("sat_preload", bus.stall_cycles, 32'hFFFF_FFFD);
    bus.stallreq_mem = 1'b1;
    cyc();
    #1 chk("sat_fe", bus.stall_cycles, 32'hFFFF_FFFE);
    cyc();
    #1 chk("sat_ff", bus.stall_cycles, 32'hFFFF_FFFF);
    cyc();
    #1 chk("sat_hold", bus.stall_cycles, 32'hFFFF_FFFF);
    bus.perf_clr = 1'b1;
    cyc();
    #1 chk("perf_clr_wins", bus.stall_cycles, 32'h0);
    bus.perf_clr = 1'b0;
    cyc();
    #1 chk("post_clr_count", bus.stall_cycles, 32'd1);
    idle_inputs();
    do_reset();

    // Async reset mid-stall and mid-HOLD
    bus.stallreq_mem = 1'b1;
    cyc();
    cyc();
    bus.excp_valid = 1'b1;
    cyc();
    #1;
    chk("mid_hold_flush", 32'(bus.flush), 32'h0);
    chk("mid_hold_stall_en", 32'(bus.stall_en), 32'h1F);
    chk("mid_hold_cycles", bus.stall_cycles, 32'd2);
    #1 reset = 1'b1;
    #1;
    chk("rst_hold_stall_en", 32'(bus.stall_en), 32'h00);
    chk("rst_hold_flush", 32'(bus.flush), 32'h0);
    chk("rst_hold_new_pc", bus.new_pc, 32'h0);
    chk("rst_hold_cycles", bus.stall_cycles, 32'h0);
    cyc();
    reset = 1'b0;
    bus.stallreq_mem = 1'b0;
    #1;
    chk("post_rst_flush", 32'(bus.flush), 32'h1);
    chk("post_rst_new_pc", bus.new_pc, 32'h20);
    idle_inputs();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
